// File: rtl/imem_loader.sv
// Instruction-memory program loader: receives a length-prefixed big-endian byte stream,
// writes the words, verifies a byte checksum, zero-fills the remainder, then releases the CPU.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned     Depth    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);
    localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(Depth - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLenHi = 3'd1;
    localparam logic [2:0] StLenLo = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;
    localparam logic [2:0] StClear = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;
    localparam logic [2:0] StError = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;

    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       len_new;
    logic [31:0]       word_new;
    logic [ADDR_W:0]   cnt_inc;

    assign accept   = rx_valid & rx_ready_q;
    assign len_new  = {len_hi_q, rx_data};
    assign word_new = {asm_q[23:0], rx_data};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        asm_d        = asm_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d     = StLenHi;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                    cnt_d       = '0;
                    bcnt_d      = '0;
                    csum_d      = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    if (len_new == 16'd0 || 32'(len_new) > Depth) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        n_d     = len_new[ADDR_W:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asm_d  = word_new;
                    csum_d = csum_q + rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = cnt_q[ADDR_W-1:0];
                        imem_wdata_d = word_new;
                        cnt_d        = cnt_inc;
                        if (cnt_inc == n_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data != csum_q) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else if (n_q == DepthCnt) begin
                        state_d     = StDone;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        // First zero-fill write goes out alongside entry to CLEAR.
                        state_d      = StClear;
                        cnt_d        = n_q;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = n_q[ADDR_W-1:0];
                        imem_wdata_d = '0;
                    end
                end
            end
            StClear: begin
                // cnt_q is the address whose write is on the outputs this cycle.
                if (cnt_q == LastAddr) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    cnt_d        = cnt_inc;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_inc[ADDR_W-1:0];
                    imem_wdata_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rx_ready_d = (state_d == StLenHi) || (state_d == StLenLo) ||
                     (state_d == StData)  || (state_d == StCsum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            len_hi_q     <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, bad checksum/length, full memory, gaps, mid-load reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wcyc[$];
    logic [31:0] exp_data [256];

    logic [7:0] nbytes [12] = '{8'hAC, 8'h08, 8'h00, 8'h03, 8'h8C, 8'h0F, 8'h00, 8'h03,
                                8'h01, 8'h09, 8'h50, 8'h20};

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(32'(imem_addr));
            wd.push_back(imem_wdata);
            wcyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wcyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rx_accept", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int done_cyc);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        done_cyc = cyc;
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic verify_full(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (i < 256 && (wa[i] != 32'(i) || wd[i] != exp_data[i])) bad++;
        end
        check({tag, "_wcount"}, 32'(wa.size()), 32'd256);
        check({tag, "_wbad"}, 32'(bad), 32'd0);
    endtask

    task automatic set_normal_exp();
        for (int i = 0; i < 256; i++) exp_data[i] = 32'd0;
        exp_data[0] = 32'hAC080003;
        exp_data[1] = 32'h8C0F0003;
        exp_data[2] = 32'h01095020;
    endtask

    task automatic run_normal(input string tag, input int max_gap, input bit mid_start);
        int dcyc;
        int last;
        clear_log();
        set_normal_exp();
        pulse_start();
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
        send_byte(8'h00, $urandom_range(0, max_gap));
        send_byte(8'h03, $urandom_range(0, max_gap));
        for (int i = 0; i < 12; i++) begin
            send_byte(nbytes[i], $urandom_range(0, max_gap));
            if (mid_start && i == 5) pulse_start();
            if (i == 3 && max_gap == 0) begin
                @(negedge clk);
                check({tag, "_w0_we"}, {31'd0, imem_we}, 32'd1);
                check({tag, "_w0_data"}, imem_wdata, 32'hAC080003);
            end
        end
        send_byte(8'hCF, $urandom_range(0, max_gap));
        @(negedge clk);
        check({tag, "_clr_first"}, {imem_we, 23'd0, imem_addr}, {1'b1, 23'd0, 8'd3});
        wait_idle(tag, dcyc);
        check({tag, "_done"}, {29'd0, done, cpu_reset, error}, {29'd0, 3'b100});
        verify_full(tag);
        last = (wcyc.size() > 0) ? wcyc[wcyc.size() - 1] : 0;
        check({tag, "_done_time"}, 32'(dcyc), 32'(last + 1));
    endtask

    initial begin
        int dcyc;
        logic [7:0] csum;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_flags", {28'd0, cpu_reset, busy, done, error}, {28'd0, 4'b1000});
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_normal("normal", 0, 1'b0);

        // Bad checksum.
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 12; i++) send_byte(nbytes[i], 0);
        send_byte(8'hCE, 0);
        @(negedge clk);
        check("badcs_flags", {28'd0, cpu_reset, busy, done, error}, {28'd0, 4'b1001});
        check("badcs_ready", {31'd0, rx_ready}, 32'd0);
        repeat (5) @(negedge clk);
        check("badcs_nclear", 32'(wa.size()), 32'd3);

        // Bad lengths.
        for (int k = 0; k < 2; k++) begin
            clear_log();
            pulse_start();
            send_byte((k == 0) ? 8'h00 : 8'h01, 0);
            send_byte((k == 0) ? 8'h00 : 8'h01, 0);
            @(negedge clk);
            check("badlen_err", {29'd0, busy, done, error}, {29'd0, 3'b001});
            check("badlen_ready", {31'd0, rx_ready}, 32'd0);
            rx_valid = 1'b1;
            repeat (3) @(negedge clk);
            check("badlen_hold", {31'd0, rx_ready}, 32'd0);
            rx_valid = 1'b0;
            check("badlen_nowr", 32'(wa.size()), 32'd0);
        end

        // Full memory, word k = k; checksum is sum(0..255) mod 256 = 0x80.
        clear_log();
        for (int i = 0; i < 256; i++) exp_data[i] = 32'(i);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        csum = 8'd0;
        for (int k = 0; k < 256; k++) begin
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'(k), 0);
            csum = csum + 8'(k);
        end
        send_byte(8'h80, 0);
        @(negedge clk);
        check("full_done", {28'd0, cpu_reset, busy, done, error}, {28'd0, 4'b0010});
        check("full_ready", {31'd0, rx_ready}, 32'd0);
        repeat (3) @(negedge clk);
        verify_full("full");

        run_normal("gaps", 3, 1'b1);

        // Reset mid-load after 6 data bytes.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) send_byte(nbytes[i], 0);
        #2 reset = 1'b0;
        #1;
        check("mrst_ready_we", {30'd0, rx_ready, imem_we}, 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'd0);
        check("mrst_wdata", imem_wdata, 32'd0);
        check("mrst_flags", {28'd0, cpu_reset, busy, done, error}, {28'd0, 4'b1000});
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_normal("rerun", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the processor's 256-word instruction memory from a byte stream before execution. It holds the CPU in reset while loading. It assembles big-endian 32-bit words, verifies a checksum, and zero-fills every unused word. It then releases the CPU. It sits between a host byte source (UART receiver or bench driver) and the instruction memory write port, in front of `single_cycle_mips`.

## Interface
- `ADDR_W`, 8: instruction memory address width; DEPTH = 2^ADDR_W words.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load session.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; transfer on `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  active-high hold for the CPU; high from reset until a load succeeds.
- `busy`  out  1  session in progress.
- `done`  out  1  last session succeeded.
- `error`  out  1  last session failed.

## Operation
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - 4N data bytes, MSB first per word (bytes AC,08,00,03 give word 0xAC080003).
  - One checksum byte: sum of all 4N data bytes mod 256. Length bytes are excluded.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, CLEAR, DONE, ERROR.
- IDLE/DONE/ERROR + `start` -> LEN_HI.
  - Entering LEN_HI: `busy`=1, `done`=0, `error`=0, `cpu_reset`=1.
  - Word counter and checksum are cleared.
- `start` is ignored while `busy`.
- LEN_HI, LEN_LO: one accepted byte each.
  - After LEN_LO: N=0 or N>DEPTH -> ERROR; otherwise -> DATA.
- DATA: bytes shift into a 32-bit assembly register, and the checksum accumulates each byte.
  - On the 4th byte of word k, the write is issued the next cycle: `imem_addr`=k.
  - After word N-1 -> CSUM.
- CSUM: one byte.
  - Match and N<DEPTH -> CLEAR.
  - Match and N=DEPTH -> DONE.
  - Mismatch -> ERROR.
- CLEAR: writes 0 to addresses N..DEPTH-1, one per cycle, then -> DONE.
- DONE: `done`=1, `busy`=0, `cpu_reset`=0. Held until next `start` or reset.
- ERROR: `error`=1, `busy`=0, `cpu_reset` stays 1.
  - Memory contents are unspecified; the CPU never runs them.
- `rx_ready`=1 only in LEN_HI, LEN_LO, DATA, CSUM. It is 0 in all other states, including the cycle a transition leaves those states.
- The word counter is ADDR_W+1 bits, so N=DEPTH is representable. The address never wraps: the last write is DEPTH-1.

## Timing
- Reset values:
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_reset`=1, `busy`=0, `done`=0, `error`=0.
  - State IDLE.
- All outputs are registered.
- Throughput: up to one byte per cycle; idle cycles on `rx_valid` are tolerated anywhere.
- Write latency: `imem_we` pulses high for exactly one cycle, in the cycle after the 4th byte's acceptance edge.
  - Writes are at least 4 cycles apart in DATA.
  - The final data write may coincide with the CSUM byte acceptance.
- CSUM -> CLEAR: the first clear write (address N) is in the cycle after the checksum byte is accepted.
- CLEAR lasts DEPTH-N cycles; DONE is entered the cycle after the DEPTH-1 write.
- N=DEPTH: DONE outputs are visible the cycle after checksum acceptance.
- Reset asserted mid-session: immediate return to reset values, including `cpu_reset`=1. A subsequent `start` restarts at address 0.

## Test plan
- **Normal load.** N=3 words 0xAC080003, 0x8C0F0003, 0x01095020; checksum 0xCF.
  - Required: writes at addresses 0, 1, 2 with those values.
  - Then 253 zero writes at 3..255.
  - Then `done`=1 and `cpu_reset`=0.
- **Bad checksum.** Same stream with checksum 0xCE.
  - Required: `error`=1, `cpu_reset`=1, `done`=0, no CLEAR writes, `rx_ready`=0.
- **Bad length.** N=0x0000 and, separately, N=0x0101.
  - Required: ERROR the cycle after LEN_LO; no `imem_we`; no further bytes accepted.
- **Full memory.** N=256, word k = k.
  - Required: last write at address 255 with value 255; no CLEAR; DONE the cycle after checksum.
- **Flow gaps and ignored start.** Normal-load stream with random idle gaps on `rx_valid`, plus a `start` pulse mid-DATA.
  - Required: identical write sequence and result; `start` has no effect.
- **Reset mid-load.** Reset asserted after 6 data bytes.
  - Required: all outputs return to reset values asynchronously.
  - Required: re-running the normal load writes address 0 first and succeeds.
